// File: rtl/rv_mc_core_ctrl.sv
// Multi-cycle sequencer for the RV32I core: owns PC/IR/load-data registers
// and drives one shared instruction/data bus with wait states and timeout.
module rv_mc_core_ctrl #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [ADDR_WIDTH-1:0] nextpc,
  input  logic                  dbg_halt_req,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  reg_write_en,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  instret,
  output logic                  halted,
  output logic                  trap
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_ld;
  logic [CNT_WIDTH-1:0]  r_instret;
  logic [TW-1:0]         r_tmo;

  logic [6:0] w_op;
  logic       w_is_store;
  logic       w_is_mem;
  logic       w_is_alu;
  logic       w_misalign;
  logic       w_tmo_hit;
  logic       w_req_st;
  logic       w_ld_ir;
  logic       w_ld_data;
  logic       w_retire;

  assign w_op       = r_ir[6:0];
  assign w_is_store = (w_op == OP_STORE);
  assign w_is_mem   = (w_op == OP_LOAD) || w_is_store;
  assign w_is_alu   = w_op inside {OP_LUI, OP_AUIPC, OP_JAL,
                                   OP_JALR, OP_BRANCH, OP_IMM,
                                   OP_REG};
  assign w_misalign = (r_pc[1:0] != 2'b00);
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_req_st   = ((r_state == S_FETCH) && !w_misalign) ||
                      (r_state == S_MEM);

  always_comb begin
    w_next    = r_state;
    w_ld_ir   = 1'b0;
    w_ld_data = 1'b0;
    w_retire  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (w_misalign) begin
          w_next = S_TRAP;
        end else if (bus_ack) begin
          w_next  = S_DECODE;
          w_ld_ir = 1'b1;
        end else if (w_tmo_hit) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (r_ir == EBREAK)
          w_next = S_HALT;
        else if (w_is_mem)
          w_next = S_MEM;
        else if (w_is_alu)
          w_next = S_WB;
        else
          w_next = S_TRAP;
      end
      S_MEM: begin
        if (bus_ack) begin
          if (w_is_store) begin
            w_retire = 1'b1;
            w_next   = dbg_halt_req ? S_HALT : S_FETCH;
          end else begin
            w_ld_data = 1'b1;
            w_next    = S_WB;
          end
        end else if (w_tmo_hit) begin
          w_next = S_TRAP;
        end
      end
      S_WB: begin
        w_retire = 1'b1;
        w_next   = dbg_halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!dbg_halt_req)
          w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_ld      <= '0;
      r_instret <= '0;
      r_tmo     <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld_ir)
        r_ir <= bus_rdata;
      if (w_ld_data)
        r_ld <= bus_rdata;
      if (w_retire) begin
        r_pc      <= nextpc;
        r_instret <= r_instret + CNT_WIDTH'(1);
      end
      // Counter only survives a cycle that stays in the same waiting state
      if (w_req_st && !bus_ack && (w_next == r_state))
        r_tmo <= r_tmo + TW'(1);
      else
        r_tmo <= '0;
    end
  end

  assign bus_req      = !rst && w_req_st;
  assign bus_we       = (r_state == S_MEM) && w_is_store;
  assign bus_addr     = (r_state == S_MEM) ? alu_result : r_pc;
  assign bus_wdata    = bus_we ? store_data : '0;
  assign reg_write_en = !rst && (r_state == S_WB) &&
                        (w_op != OP_BRANCH);
  assign halted       = !rst && (r_state == S_HALT);
  assign trap         = !rst && (r_state == S_TRAP);
  assign state        = r_state;
  assign pc           = r_pc;
  assign ir           = r_ir;
  assign ld_data      = r_ld;
  assign instret      = r_instret;

endmodule

// File: tb/tb_rv_mc_core_ctrl.sv
// Bench for rv_mc_core_ctrl: a per-instruction phase model predicts every
// cycle of bus, strobe and register activity for directed and random code.
module tb_rv_mc_core_ctrl;

  localparam int          TMO = 4;
  localparam logic [31:0] RPC = 32'h0;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_H = 3'd5;
  localparam logic [2:0] ST_T = 3'd6;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LW    = 32'h0000_2103;
  localparam logic [31:0] I_SW    = 32'h0020_2223;
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_EBRK  = 32'h0010_0073;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  logic        clk, rst;
  logic        bus_req, bus_we, bus_ack, dbg_halt_req;
  logic        reg_write_en, halted, trap;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [31:0] alu_result, store_data, nextpc;
  logic [31:0] pc, ir, ld_data, instret;
  logic [2:0]  state;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [2:0]  st;
    logic        req, we, rwe, ack, dbg;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] pc, ir, cnt, ld;
  } ph_t;

  ph_t         q[$];
  logic [31:0] e_pc, e_ir, e_cnt, e_ld;
  logic [31:0] d_npc, d_addr, d_sdata;

  rv_mc_core_ctrl #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (RPC),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .nextpc      (nextpc),
    .dbg_halt_req(dbg_halt_req),
    .pc          (pc),
    .ir          (ir),
    .ld_data     (ld_data),
    .reg_write_en(reg_write_en),
    .state       (state),
    .instret     (instret),
    .halted      (halted),
    .trap        (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h",
               tag, $time, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] st,
                      input logic req, input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic rwe, input logic ack,
                      input logic [31:0] rdata,
                      input logic dbg);
    ph_t p;
    p.st = st; p.req = req; p.we = we;
    p.addr = addr; p.wdata = wdata; p.rwe = rwe;
    p.ack = ack; p.rdata = rdata; p.dbg = dbg;
    p.pc = e_pc; p.ir = e_ir; p.cnt = e_cnt; p.ld = e_ld;
    q.push_back(p);
  endtask

  task automatic play();
    foreach (q[k]) begin
      if (k == 0) begin
        nextpc     = d_npc;
        alu_result = d_addr;
        store_data = d_sdata;
        #1;
      end
      chk("state", 32'(state), 32'(q[k].st));
      chk("bus_req", 32'(bus_req), 32'(q[k].req));
      chk("bus_we", 32'(bus_we), 32'(q[k].we));
      if (q[k].req)
        chk("bus_addr", bus_addr, q[k].addr);
      chk("bus_wdata", bus_wdata, q[k].wdata);
      chk("reg_write_en", 32'(reg_write_en), 32'(q[k].rwe));
      chk("halted", 32'(halted), 32'(q[k].st == ST_H));
      chk("trap", 32'(trap), 32'(q[k].st == ST_T));
      chk("pc", pc, q[k].pc);
      chk("ir", ir, q[k].ir);
      chk("instret", instret, q[k].cnt);
      chk("ld_data", ld_data, q[k].ld);
      bus_ack      = q[k].ack;
      bus_rdata    = q[k].rdata;
      dbg_halt_req = q[k].dbg;
      @(negedge clk);
    end
  endtask

  task automatic halt_phases(input int n);
    for (int i = 0; i < n; i++)
      push(ST_H, 0, 0, 0, 0, 0, 0, 0, i < n - 1);
  endtask

  task automatic retire(input logic [31:0] npc, input int hold);
    e_pc  = npc;
    e_cnt = e_cnt + 1;
    if (hold > 0)
      halt_phases(hold);
  endtask

  task automatic run_instr(input logic [31:0] instr,
                           input int wf, input int wm,
                           input logic [31:0] npc,
                           input logic [31:0] addr,
                           input logic [31:0] sdata,
                           input logic [31:0] rdata,
                           input int hold,
                           output bit trapped);
    logic [6:0] op;
    bit is_st, is_mem, is_alu, hd;
    op     = instr[6:0];
    is_st  = (op == 7'b0100011);
    is_mem = is_st || (op == 7'b0000011);
    is_alu = op inside {7'b0110111, 7'b0010111, 7'b1101111,
                        7'b1100111, 7'b1100011, 7'b0010011,
                        7'b0110011};
    hd      = (hold > 0);
    trapped = 1'b0;
    d_npc   = npc;
    d_addr  = addr;
    d_sdata = sdata;
    q.delete();
    if (e_pc[1:0] != 2'b00) begin
      push(ST_F, 0, 0, 0, 0, 0, 0, 0, 0);
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < wf && i < TMO; i++)
        push(ST_F, 1, 0, e_pc, 0, 0, 0, 0, 0);
      if (wf >= TMO) begin
        trapped = 1'b1;
      end else begin
        push(ST_F, 1, 0, e_pc, 0, 0, 1, instr, 0);
        e_ir = instr;
        push(ST_D, 0, 0, 0, 0, 0, 0, 0, 0);
        push(ST_E, 0, 0, 0, 0, 0, 0, 0, 0);
        if (instr == I_EBRK) begin
          halt_phases(hd ? hold : 1);
        end else if (is_mem) begin
          for (int i = 0; i < wm && i < TMO; i++)
            push(ST_M, 1, is_st, addr, is_st ? sdata : 0,
                 0, 0, 0, 0);
          if (wm >= TMO) begin
            trapped = 1'b1;
          end else if (is_st) begin
            push(ST_M, 1, 1, addr, sdata, 0, 1, rdata, hd);
            retire(npc, hold);
          end else begin
            push(ST_M, 1, 0, addr, 0, 0, 1, rdata, 0);
            e_ld = rdata;
            push(ST_W, 0, 0, 0, 0, 1, 0, 0, hd);
            retire(npc, hold);
          end
        end else if (is_alu) begin
          push(ST_W, 0, 0, 0, 0, op != 7'b1100011, 0, 0, hd);
          retire(npc, hold);
        end else begin
          trapped = 1'b1;
        end
      end
    end
    // Late acks while trapped must be ignored
    if (trapped)
      for (int i = 0; i < 3; i++)
        push(ST_T, 0, 0, 0, 0, 0, 1, $urandom, 0);
    play();
  endtask

  task automatic do_reset();
    #2;
    rst          = 1'b1;
    bus_ack      = 1'b0;
    dbg_halt_req = 1'b0;
    #1;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_pc", pc, RPC);
    chk("rst_state", 32'(state), 32'(ST_F));
    chk("rst_trap", 32'(trap), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_rwe", 32'(reg_write_en), 0);
    chk("rst_instret", instret, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ld_data", ld_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    e_pc  = RPC;
    e_ir  = 0;
    e_cnt = 0;
    e_ld  = 0;
  endtask

  function automatic logic [6:0] op_of(input int i);
    case (i)
      0:       return 7'b0000011;
      1:       return 7'b0100011;
      2:       return 7'b0110111;
      3:       return 7'b0010111;
      4:       return 7'b1101111;
      5:       return 7'b1100111;
      6:       return 7'b1100011;
      7:       return 7'b0010011;
      default: return 7'b0110011;
    endcase
  endfunction

  initial begin
    bit          t;
    int          r, wf, wm, hold;
    logic [31:0] rnd, instr, npc;
    logic [6:0]  op;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus_ack = 0; bus_rdata = 0; dbg_halt_req = 0;
    alu_result = 0; store_data = 0; nextpc = 0;
    @(negedge clk);
    do_reset();

    run_instr(I_ADDI, 0, 0, 32'h4, 0, 0, 0, 0, t);
    run_instr(I_LW, 0, 3, 32'h8, 32'h0, 0,
              32'hDEAD_BEEF, 0, t);
    run_instr(I_SW, 1, 0, 32'hC, 32'h40,
              32'h1234_5678, 0, 0, t);
    run_instr(I_BEQ, 0, 0, 32'h100, 0, 0, 0, 0, t);
    run_instr(I_BEQ, 0, 0, 32'h102, 0, 0, 0, 0, t);
    run_instr(I_ADDI, 0, 0, 32'h106, 0, 0, 0, 0, t);
    chk("misalign_trap", 32'(t), 1);
    do_reset();

    run_instr(I_ADDI, 6, 0, 32'h4, 0, 0, 0, 0, t);
    chk("fetch_timeout", 32'(t), 1);
    do_reset();
    run_instr(I_LW, 0, 5, 32'h4, 32'h80, 0, 0, 0, t);
    chk("mem_timeout", 32'(t), 1);
    do_reset();

    run_instr(I_ADDI, 0, 0, 32'h4, 0, 0, 0, 0, t);
    run_instr(I_EBRK, 0, 0, 32'h8, 0, 0, 0, 2, t);
    run_instr(I_ADDI, 0, 0, 32'h8, 0, 0, 0, 3, t);
    run_instr(I_ADDI, 2, 0, 32'hC, 0, 0, 0, 0, t);
    q.delete();
    push(ST_F, 1, 0, e_pc, 0, 0, 0, 0, 0);
    push(ST_F, 1, 0, e_pc, 0, 0, 0, 0, 0);
    play();
    do_reset();
    run_instr(I_ECALL, 0, 0, 32'h4, 0, 0, 0, 0, t);
    chk("ecall_trap", 32'(t), 1);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 39);
      rnd = $urandom;
      op  = op_of(r % 9);
      if (r == 0)
        instr = I_EBRK;
      else if (r == 1)
        instr = I_ECALL;
      else if (r == 2)
        instr = {rnd[31:7], 7'b0001111};
      else
        instr = {rnd[31:7], op};
      wf = ($urandom_range(0, 15) == 0) ?
           TMO + $urandom_range(0, 2) : $urandom_range(0, 2);
      wm = ($urandom_range(0, 15) == 0) ?
           TMO + $urandom_range(0, 2) : $urandom_range(0, 3);
      npc = e_pc + 32'd4;
      if (op inside {7'b1101111, 7'b1100111, 7'b1100011} &&
          $urandom_range(0, 1) == 1)
        npc = 32'($urandom_range(0, 16383)) << 2;
      hold = ($urandom_range(0, 9) == 0) ?
             $urandom_range(1, 3) : 0;
      run_instr(instr, wf, wm, npc, $urandom, $urandom,
                $urandom, hold, t);
      if (t)
        do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
